// File: rtl/clk_meas_pkg.sv
// Shared types and width helpers for the clock period meter.
// Imported by the sync front end and the measurement top level.
package clk_meas_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      MEASURE,
      DONE
   } state_t;

   localparam int MIN_SYNC_STAGES = 2;

   // Accumulator holds the sum of 2^avg_log2 period counts.
   function automatic int acc_width(input int cnt_w, input int avg_log2);
      return cnt_w + avg_log2;
   endfunction

   // Index must be able to hold 2^avg_log2 - 1.
   function automatic int idx_width(input int avg_log2);
      return avg_log2 + 1;
   endfunction

endpackage

// File: rtl/clk_period_meas_if.sv
// Result channel of the clock period meter.
// Master drives the result, slave consumes it with i_ready.
interface clk_period_meas_if #(
   parameter int CNT_WIDTH = 16
) ();

   logic                 o_valid;
   logic                 i_ready;
   logic [CNT_WIDTH-1:0] o_period;
   logic [CNT_WIDTH-1:0] o_high;
   logic                 o_timeout;

   modport master (
      output o_valid,
      output o_period,
      output o_high,
      output o_timeout,
      input  i_ready
   );

   modport slave (
      input  o_valid,
      input  o_period,
      input  o_high,
      input  o_timeout,
      output i_ready
   );

endinterface

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous level,
// followed by a delay flop for rise/fall pulse detection.
module sync_edge_det
   import clk_meas_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic n_rst,
   input  logic d,
   output logic sync,
   output logic rise,
   output logic fall
);

   localparam int STAGES = (SYNC_STAGES < MIN_SYNC_STAGES) ?
                           MIN_SYNC_STAGES : SYNC_STAGES;

   logic [STAGES-1:0] sync_q;
   logic              dly_q;

   // Shift the async input through the synchroniser chain.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sync_q <= '0;
         dly_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d};
         dly_q  <= sync_q[STAGES-1];
      end
   end

   assign sync = sync_q[STAGES-1];
   assign rise = sync & ~dly_q;
   assign fall = ~sync & dly_q;

endmodule

// File: rtl/clk_period_meas.sv
// Measures period and high time of a slow async clock in clk cycles,
// averaged over 2^AVG_LOG2 periods, with a timeout for stuck inputs.
module clk_period_meas
   import clk_meas_pkg::*;
#(
   parameter int CNT_WIDTH   = 16,
   parameter int SYNC_STAGES = 2,
   parameter int AVG_LOG2    = 2
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  i_en,
   input  logic                  i_clk_in,
   output logic                  o_busy,
   clk_period_meas_if.master     res
);

   localparam int CW    = CNT_WIDTH;
   localparam int ACC_W = acc_width(CNT_WIDTH, AVG_LOG2);
   localparam int IDX_W = idx_width(AVG_LOG2);

   localparam logic [CW-1:0]    TO_LIM = '1;
   localparam logic [IDX_W-1:0] LAST   = IDX_W'((1 << AVG_LOG2) - 1);

   logic sync;
   logic rise;
   logic fall;

   state_t            state, state_n;
   logic [CW-1:0]     per_cnt, per_n;
   logic [CW-1:0]     hi_cnt, hi_n;
   logic              hi_stop, hi_stop_n;
   logic [ACC_W-1:0]  acc_p, acc_p_n;
   logic [ACC_W-1:0]  acc_h, acc_h_n;
   logic [IDX_W-1:0]  idx, idx_n;
   logic [CW-1:0]     res_p, res_p_n;
   logic [CW-1:0]     res_h, res_h_n;
   logic              res_to, res_to_n;
   logic [ACC_W-1:0]  sum_p;
   logic [ACC_W-1:0]  sum_h;

   sync_edge_det #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .n_rst (n_rst),
      .d     (i_clk_in),
      .sync  (sync),
      .rise  (rise),
      .fall  (fall)
   );

   // State, counters, accumulators and held result.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state   <= IDLE;
         per_cnt <= '0;
         hi_cnt  <= '0;
         hi_stop <= 1'b0;
         acc_p   <= '0;
         acc_h   <= '0;
         idx     <= '0;
         res_p   <= '0;
         res_h   <= '0;
         res_to  <= 1'b0;
      end else begin
         state   <= state_n;
         per_cnt <= per_n;
         hi_cnt  <= hi_n;
         hi_stop <= hi_stop_n;
         acc_p   <= acc_p_n;
         acc_h   <= acc_h_n;
         idx     <= idx_n;
         res_p   <= res_p_n;
         res_h   <= res_h_n;
         res_to  <= res_to_n;
      end
   end

   // Next-state and datapath: ARM catches a rise, MEASURE sums
   // periods until enough are collected or the counter saturates.
   always_comb begin
      state_n   = state;
      per_n     = per_cnt;
      hi_n      = hi_cnt;
      hi_stop_n = hi_stop;
      acc_p_n   = acc_p;
      acc_h_n   = acc_h;
      idx_n     = idx;
      res_p_n   = res_p;
      res_h_n   = res_h;
      res_to_n  = res_to;
      sum_p     = acc_p + ACC_W'(per_cnt);
      sum_h     = acc_h + ACC_W'(hi_cnt);

      if (!i_en) begin
         state_n   = IDLE;
         per_n     = '0;
         hi_n      = '0;
         hi_stop_n = 1'b0;
         acc_p_n   = '0;
         acc_h_n   = '0;
         idx_n     = '0;
      end else begin
         unique case (state)
            IDLE: begin
               state_n = ARM;
               per_n   = '0;
            end
            ARM: begin
               if (rise) begin
                  state_n   = MEASURE;
                  per_n     = CW'(1);
                  hi_n      = CW'(1);
                  hi_stop_n = 1'b0;
                  acc_p_n   = '0;
                  acc_h_n   = '0;
                  idx_n     = '0;
               end else if (per_cnt == TO_LIM) begin
                  state_n  = DONE;
                  res_p_n  = '1;
                  res_h_n  = sync ? '1 : '0;
                  res_to_n = 1'b1;
               end else begin
                  per_n = per_cnt + CW'(1);
               end
            end
            MEASURE: begin
               if (rise) begin
                  acc_p_n   = sum_p;
                  acc_h_n   = sum_h;
                  idx_n     = idx + IDX_W'(1);
                  per_n     = CW'(1);
                  hi_n      = CW'(1);
                  hi_stop_n = 1'b0;
                  if (idx == LAST) begin
                     state_n  = DONE;
                     res_p_n  = CW'(sum_p >> AVG_LOG2);
                     res_h_n  = CW'(sum_h >> AVG_LOG2);
                     res_to_n = 1'b0;
                  end
               end else if (per_cnt == TO_LIM) begin
                  state_n  = DONE;
                  res_p_n  = '1;
                  res_h_n  = sync ? '1 : '0;
                  res_to_n = 1'b1;
               end else begin
                  per_n = per_cnt + CW'(1);
                  if (fall) begin
                     hi_stop_n = 1'b1;
                  end else if (!hi_stop) begin
                     hi_n = hi_cnt + CW'(1);
                  end
               end
            end
            DONE: begin
               if (res.i_ready) begin
                  state_n = ARM;
                  per_n   = '0;
                  hi_n    = '0;
               end
            end
            default: begin
               state_n = IDLE;
            end
         endcase
      end
   end

   assign res.o_valid   = (state == DONE);
   assign res.o_period  = res_p;
   assign res.o_high    = res_h;
   assign res.o_timeout = res_to;
   assign o_busy        = (state == ARM) | (state == MEASURE);

endmodule
